// File: rtl/cpu_run_controller.sv
// Run/step sequencer for the Hack-style CPU: produces a single clock-enable
// for CPU/ROM/RAM with divided free-run, single-step, halt, PC breakpoint and write watchpoint.
module cpu_run_controller #(
   parameter int unsigned DIV = 2,
   parameter int unsigned AW  = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run_mode,
   input  logic          step_btn,
   input  logic          halt_req,
   input  logic          bp_en,
   input  logic [AW-1:0] bp_addr,
   input  logic          watch_en,
   input  logic [AW-1:0] watch_addr,
   input  logic [AW-1:0] pc,
   input  logic          writeM,
   input  logic [AW-1:0] addressM,
   output logic          cpu_en,
   output logic [1:0]    state,
   output logic [1:0]    hit_cause,
   output logic [31:0]   cycle_count
);

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_BRK  = 2'd3
   } run_state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   run_state_t  state_q, state_d;
   logic [1:0]  cause_q, cause_d;
   logic [7:0]  div_cnt;
   logic [31:0] cycle_cnt;
   logic        step_q;
   logic        step_edge, bp_match, watch_match, div_last;

   assign step_edge   = step_btn & ~step_q;
   assign bp_match    = bp_en & (pc == bp_addr);
   assign div_last    = (div_cnt == DIV_LAST);
   assign watch_match = watch_en & writeM & (addressM == watch_addr) & cpu_en;

   // Gated by reset so no enable is ever issued on a reset edge.
   always_comb begin
      cpu_en = 1'b0;
      case (state_q)
         ST_RUN:  cpu_en = div_last & run_mode & ~halt_req & ~bp_match;
         ST_STEP: cpu_en = ~halt_req;
         default: cpu_en = 1'b0;
      endcase
      cpu_en = cpu_en & reset;
   end

   always_comb begin
      state_d = state_q;
      cause_d = 2'b00;
      case (state_q)
         ST_HALT: begin
            if (halt_req)       state_d = ST_HALT;
            else if (run_mode)  state_d = ST_RUN;
            else if (step_edge) state_d = ST_STEP;
         end
         ST_RUN: begin
            if (halt_req || !run_mode) begin
               state_d = ST_HALT;
            end else if (div_last && bp_match) begin
               state_d = ST_BRK;
               cause_d = 2'b01;
            end else if (watch_match) begin
               state_d = ST_BRK;
               cause_d = 2'b10;
            end
         end
         ST_STEP: state_d = ST_HALT;
         ST_BRK: begin
            if (halt_req || !run_mode) state_d = ST_HALT;
            else if (step_edge)        state_d = ST_STEP;
            else                       cause_d = cause_q;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_HALT;
         cause_q   <= 2'b00;
         div_cnt   <= '0;
         cycle_cnt <= '0;
         step_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         step_q  <= step_btn;
         if (cpu_en) cycle_cnt <= cycle_cnt + 32'd1;
         if (state_q == ST_RUN && state_d == ST_RUN)
            div_cnt <= div_last ? '0 : div_cnt + 8'd1;
         else
            div_cnt <= '0;
      end
   end

   assign state       = state_q;
   assign hit_cause   = cause_q;
   assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: a cycle-level behavioural model checked every
// cycle, plus hand-computed milestones for each scenario.
module tb_cpu_run_controller;

   localparam int unsigned DIV = 2;
   localparam int unsigned AW  = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          run_mode = 1'b0;
   logic          step_btn = 1'b1;
   logic          halt_req = 1'b0;
   logic          bp_en = 1'b0;
   logic          watch_en = 1'b0;
   logic          pc_clr = 1'b0;
   logic          wm_mode = 1'b0;
   logic [AW-1:0] bp_addr = '0;
   logic [AW-1:0] watch_addr = '0;
   logic [AW-1:0] pc = '0;
   logic          writeM;
   logic [AW-1:0] addressM;
   logic          cpu_en;
   logic [1:0]    state, hit_cause;
   logic [31:0]   cycle_count;

   int n_pass = 0;
   int n_total = 0;
   bit chk_on = 1'b0;

   // model: mode 0 HALT, 1 RUN, 2 STEP, 3 BRK; m_age = cycles spent in RUN since entry
   int          m_mode = 0;
   int unsigned m_age = 0;
   logic [1:0]  m_cause = 2'b00;
   logic [31:0] m_count = '0;
   logic        m_stepq = 1'b1;

   cpu_run_controller #(.DIV(DIV), .AW(AW)) dut (
      .clk(clk), .reset(reset), .run_mode(run_mode), .step_btn(step_btn),
      .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .watch_en(watch_en),
      .watch_addr(watch_addr), .pc(pc), .writeM(writeM), .addressM(addressM),
      .cpu_en(cpu_en), .state(state), .hit_cause(hit_cause), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // CPU stub: PC advances once per enable; writes address 2 while executing pc==3
   always @(posedge clk) begin
      if (pc_clr)      pc <= '0;
      else if (cpu_en) pc <= pc + AW'(1);
   end
   assign writeM   = wm_mode;
   assign addressM = (wm_mode && pc == AW'(3)) ? AW'(2) : AW'(9);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      logic se, bp, en, wm;
      int   nxt;
      se = step_btn & ~m_stepq;
      bp = bp_en && (pc == bp_addr);
      en = 1'b0;
      if (reset) begin
         if (m_mode == 1)
            en = ((m_age % DIV) == DIV - 1) && run_mode && !halt_req && !bp;
         else if (m_mode == 2)
            en = !halt_req;
      end
      wm = watch_en && writeM && (addressM == watch_addr) && en;
      if (chk_on) begin
         check("cyc_cpu_en", 32'(cpu_en), 32'(en));
         check("cyc_state", 32'(state), 32'(m_mode));
         check("cyc_hit_cause", 32'(hit_cause), 32'(m_cause));
         check("cyc_cycle_count", cycle_count, m_count);
      end
      if (!reset) begin
         m_mode = 0; m_age = 0; m_cause = 2'b00; m_count = '0; m_stepq = 1'b1;
      end else begin
         case (m_mode)
            0: nxt = halt_req ? 0 : (run_mode ? 1 : (se ? 2 : 0));
            1: begin
               if (halt_req || !run_mode) nxt = 0;
               else if (bp && (m_age % DIV) == DIV - 1) begin nxt = 3; m_cause = 2'b01; end
               else if (wm) begin nxt = 3; m_cause = 2'b10; end
               else nxt = 1;
            end
            2: nxt = 0;
            default: nxt = (halt_req || !run_mode) ? 0 : (se ? 2 : 3);
         endcase
         if (nxt != 3) m_cause = 2'b00;
         if (en) m_count = m_count + 32'd1;
         m_age   = (nxt == 1 && m_mode == 1) ? m_age + 1 : 0;
         m_mode  = nxt;
         m_stepq = step_btn;
      end
   end

   initial begin
      // reset held 3 edges with the button down, then button held 5 more cycles
      tick(1);
      chk_on = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(5);
      check("rst_state", 32'(state), 32'd0);
      check("rst_cpu_en", 32'(cpu_en), 32'd0);
      check("rst_count", cycle_count, 32'd0);
      step_btn = 1'b0;

      // free run: 20 RUN cycles at DIV=2 give 10 enables
      run_mode = 1'b1;
      tick(21);
      check("run_count", cycle_count, 32'd10);
      run_mode = 1'b0;
      tick(1);
      check("run_stop_state", 32'(state), 32'd0);
      tick(3);
      check("run_frozen", cycle_count, 32'd10);

      // three 4-cycle presses, one enable each
      for (int i = 0; i < 3; i++) begin
         step_btn = 1'b1;
         tick(4);
         step_btn = 1'b0;
         tick(4);
      end
      check("step_count", cycle_count, 32'd13);

      // breakpoint at pc 5, then resume by stepping with run_mode high
      pc_clr = 1'b1;
      tick(1);
      pc_clr = 1'b0;
      bp_en = 1'b1;
      bp_addr = AW'(5);
      run_mode = 1'b1;
      tick(20);
      check("bp_state", 32'(state), 32'd3);
      check("bp_cause", 32'(hit_cause), 32'd1);
      check("bp_pc", 32'(pc), 32'd5);
      check("bp_count", cycle_count, 32'd18);
      step_btn = 1'b1;
      tick(1);
      check("bp_step_state", 32'(state), 32'd2);
      check("bp_step_en", 32'(cpu_en), 32'd1);
      tick(1);
      check("bp_halt_state", 32'(state), 32'd0);
      check("bp_pc_after", 32'(pc), 32'd6);
      tick(1);
      check("bp_resume_state", 32'(state), 32'd1);
      check("bp_resume_count", cycle_count, 32'd19);
      step_btn = 1'b0;
      bp_en = 1'b0;
      run_mode = 1'b0;
      tick(2);

      // watchpoint on the write made by the 4th enable
      pc_clr = 1'b1;
      tick(1);
      pc_clr = 1'b0;
      watch_en = 1'b1;
      watch_addr = AW'(2);
      wm_mode = 1'b1;
      run_mode = 1'b1;
      tick(15);
      check("wp_state", 32'(state), 32'd3);
      check("wp_cause", 32'(hit_cause), 32'd2);
      check("wp_count", cycle_count, 32'd23);
      check("wp_pc", 32'(pc), 32'd4);
      run_mode = 1'b0;
      tick(1);
      check("wp_exit_state", 32'(state), 32'd0);
      check("wp_exit_cause", 32'(hit_cause), 32'd0);
      watch_en = 1'b0;
      wm_mode = 1'b0;

      // halt_req in an enable cycle of RUN
      run_mode = 1'b1;
      tick(2);
      halt_req = 1'b1;
      #1;
      check("halt_cpu_en", 32'(cpu_en), 32'd0);
      tick(1);
      check("halt_state", 32'(state), 32'd0);
      check("halt_count", cycle_count, 32'd23);
      halt_req = 1'b0;
      run_mode = 1'b0;
      tick(2);

      // counter wrap on a single step
      dut.cycle_cnt = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      step_btn = 1'b1;
      tick(2);
      check("wrap_count", cycle_count, 32'd0);
      step_btn = 1'b0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
